// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues single-outstanding word requests to imem,
// buffers returned words with their PC and hands {pc, instr} to decode; redirects flush.
module instr_fetch_unit #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] fetch_pc
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]   req_pc_q, req_pc_d;
    logic [XLEN-1:0]   pc_mem_q    [FIFO_DEPTH];
    logic [XLEN-1:0]   pc_mem_d    [FIFO_DEPTH];
    logic [31:0]       instr_mem_q [FIFO_DEPTH];
    logic [31:0]       instr_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              req_hs;
    logic              push;
    logic              pop;
    logic              flush;

    // State and control registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Buffer storage needs no reset: entries are only read when count_q says so
    always_ff @(posedge clk) begin
        pc_mem_q    <= pc_mem_d;
        instr_mem_q <= instr_mem_d;
    end

    // Next-state and fetch-address logic; redirect overrides the normal transition
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        push       = 1'b0;
        flush      = 1'b0;
        req_hs     = imem_req_valid && imem_req_ready;
        pop        = out_valid && out_ready;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (req_hs) begin
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + XLEN'(4);
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    push    = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem_rsp_valid) state_d = S_REQ;
            end
            default: state_d = S_IDLE;
        endcase
        if (redirect_valid) begin
            flush      = 1'b1;
            push       = 1'b0;
            fetch_pc_d = redirect_pc & ~XLEN'(3);
            case (state_q)
                S_REQ:           state_d = req_hs ? S_DRAIN : S_REQ;
                S_WAIT, S_DRAIN: state_d = imem_rsp_valid ? S_REQ : S_DRAIN;
                default:         state_d = S_REQ;
            endcase
        end
    end

    // Instruction buffer bookkeeping; simultaneous push and pop both apply
    always_comb begin
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_mem_d[wr_ptr_q]    = req_pc_q;
                instr_mem_d[wr_ptr_q] = imem_rsp_data;
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Outputs; only one request is ever outstanding, so the credit check is the buffer count
    always_comb begin
        imem_req_valid = 1'b0;
        if (state_q == S_REQ) imem_req_valid = (count_q < CNT_W'(FIFO_DEPTH));
        imem_req_addr  = fetch_pc_q;
        fetch_pc       = fetch_pc_q;
        out_valid      = (count_q != '0);
        out_pc         = pc_mem_q[rd_ptr_q];
        out_instr      = instr_mem_q[rd_ptr_q];
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: behavioural imem with programmable latency plus a
// scoreboard of expected {pc, instr} deliveries checked at every decode handshake.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [31:0] fetch_pc;

    typedef struct packed {logic [31:0] pc; logic [31:0] instr;} exp_t;
    typedef struct {logic [31:0] addr; int due;} pend_t;

    exp_t        exp_q[$];
    pend_t       pend_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          mem_lat = 1;
    int          acc_cnt = 0;
    logic [31:0] last_acc = '0;

    instr_fetch_unit #(.XLEN(32), .RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .fetch_pc(fetch_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_seq(input logic [31:0] start, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.pc    = start + 32'(4 * i);
            e.instr = instr_of(e.pc);
            exp_q.push_back(e);
        end
    endtask

    // Instruction memory: in-order responses, mem_lat cycles after each accepted request
    initial begin
        pend_t p;
        forever begin
            @(negedge clk);
            cyc++;
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = instr_of(pend_q[0].addr);
                void'(pend_q.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'hDEAD_BEEF;
            end
            if (rst === 1'b1 && imem_req_valid === 1'b1 && imem_req_ready) begin
                checks++;
                if (imem_req_addr[1:0] !== 2'b00) begin errors++; $display("FAIL req_align: got addr %h, required word aligned", imem_req_addr); end
                p.addr = imem_req_addr;
                p.due  = cyc + mem_lat;
                pend_q.push_back(p);
                acc_cnt++;
                last_acc = imem_req_addr;
            end
        end
    end

    // Decode side: every accepted delivery must match the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && out_valid === 1'b1 && out_ready && !redirect_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL unexpected_out: got pc %h, required no delivery", out_pc);
                end else begin
                    e = exp_q.pop_front();
                    if (out_pc !== e.pc) begin errors++; $display("FAIL out_pc: got %h, required %h", out_pc, e.pc); end
                    checks++;
                    if (out_instr !== e.instr) begin errors++; $display("FAIL out_instr: got %h, required %h (pc %h)", out_instr, e.instr, e.pc); end
                end
            end
        end
    end

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) step(1);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL %s_drain: got %0d entries left, required 0", name, exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_reset;
        rst = 1'b0; out_ready = 1'b0; imem_req_ready = 1'b1;
        step(3);
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b, required 0", imem_req_valid); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        checks++; if (fetch_pc !== RST_PC) begin errors++; $display("FAIL reset_fetch_pc: got %h, required %h", fetch_pc, RST_PC); end
        rst = 1'b1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL idle_req_valid: got %b, required 0", imem_req_valid); end
        step(1);
        checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL first_req_valid: got %b, required 1", imem_req_valid); end
        checks++; if (imem_req_addr !== RST_PC) begin errors++; $display("FAIL first_req_addr: got %h, required %h", imem_req_addr, RST_PC); end
    endtask

    task automatic test_backpressure_and_stream;
        step(10);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %b, required 1", out_valid); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %b, required 0", imem_req_valid); end
        checks++; if (acc_cnt !== 2) begin errors++; $display("FAIL bp_req_count: got %0d, required 2", acc_cnt); end
        checks++; if (fetch_pc !== 32'h4) begin errors++; $display("FAIL bp_fetch_pc: got %h, required 00000004", fetch_pc); end
        checks++; if (out_pc !== RST_PC) begin errors++; $display("FAIL bp_head_pc: got %h, required %h", out_pc, RST_PC); end
        expect_seq(RST_PC, 8);
        out_ready = 1'b1;
        wait_drain("stream", 100);
        out_ready = 1'b0;
    endtask

    task automatic test_redirect_wait;
        step(6);
        redirect_valid = 1'b1; redirect_pc = 32'h200; mem_lat = 4;
        step(1);
        redirect_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rdw_flush: got out_valid %b, required 0", out_valid); end
        checks++; if (fetch_pc !== 32'h200) begin errors++; $display("FAIL rdw_fetch_pc: got %h, required 00000200", fetch_pc); end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin errors++; $display("FAIL rdw_req: got valid %b addr %h, required 1 00000200", imem_req_valid, imem_req_addr); end
        step(1);
        checks++; if (imem_req_valid !== 1'b0 || fetch_pc !== 32'h204) begin errors++; $display("FAIL rdw_wait: got valid %b fetch_pc %h, required 0 00000204", imem_req_valid, fetch_pc); end
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        step(1);
        redirect_valid = 1'b0;
        checks++; if (fetch_pc !== 32'h100) begin errors++; $display("FAIL rdw_target: got %h, required 00000100", fetch_pc); end
        checks++; if (imem_req_valid !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rdw_drain: got req %b out %b, required 0 0", imem_req_valid, out_valid); end
        begin
            int acc0;
            acc0 = acc_cnt;
            expect_seq(32'h100, 3);
            out_ready = 1'b1;
            for (int i = 0; i < 20 && acc_cnt == acc0; i++) step(1);
        end
        checks++; if (last_acc !== 32'h100) begin errors++; $display("FAIL rdw_next_req: got %h, required 00000100", last_acc); end
        mem_lat = 1;
        wait_drain("rdw", 60);
        out_ready = 1'b0;
    endtask

    task automatic test_redirect_rsp_pop;
        step(8);
        mem_lat = 3;
        expect_seq(32'h10C, 1);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (imem_rsp_valid) break;
        end
        checks++; if (imem_rsp_valid !== 1'b1) begin errors++; $display("FAIL rrp_rsp_timeout: got rsp_valid %b, required 1", imem_rsp_valid); end
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h110) begin errors++; $display("FAIL rrp_head: got valid %b pc %h, required 1 00000110", out_valid, out_pc); end
        redirect_valid = 1'b1; redirect_pc = 32'h302; out_ready = 1'b1;
        step(1);
        redirect_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rrp_flush: got out_valid %b, required 0", out_valid); end
        checks++; if (fetch_pc !== 32'h300) begin errors++; $display("FAIL rrp_fetch_pc: got %h, required 00000300", fetch_pc); end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300) begin errors++; $display("FAIL rrp_req: got valid %b addr %h, required 1 00000300", imem_req_valid, imem_req_addr); end
        mem_lat = 1;
        expect_seq(32'h300, 2);
        wait_drain("rrp", 40);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midflight;
        step(8);
        redirect_valid = 1'b1; redirect_pc = 32'h400; mem_lat = 3;
        step(1);
        redirect_valid = 1'b0;
        step(1);
        checks++; if (imem_req_valid !== 1'b0 || fetch_pc !== 32'h404) begin errors++; $display("FAIL rmf_wait: got valid %b fetch_pc %h, required 0 00000404", imem_req_valid, fetch_pc); end
        rst = 1'b0; imem_req_ready = 1'b0;
        step(1);
        rst = 1'b1;
        checks++; if (fetch_pc !== RST_PC || out_valid !== 1'b0) begin errors++; $display("FAIL rmf_reset: got fetch_pc %h out_valid %b, required %h 0", fetch_pc, out_valid, RST_PC); end
        for (int i = 0; i < 20 && pend_q.size() != 0; i++) step(1);
        checks++; if (pend_q.size() != 0) begin errors++; $display("FAIL rmf_stale_timeout: got %0d pending, required 0", pend_q.size()); end
        step(1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmf_stale_ignored: got out_valid %b, required 0", out_valid); end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin errors++; $display("FAIL rmf_restart: got valid %b addr %h, required 1 %h", imem_req_valid, imem_req_addr, RST_PC); end
        mem_lat = 1;
        imem_req_ready = 1'b1;
        expect_seq(RST_PC, 3);
        out_ready = 1'b1;
        wait_drain("rmf", 40);
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_backpressure_and_stream();
        test_redirect_wait();
        test_redirect_rsp_pop();
        test_reset_midflight();
        step(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
